mips_dcache_wb: RTL

- Parametrised, direct-mapped, write-back, write-allocate data cache.
- Sits between the MEM stage and data memory, replacing the direct word interface.
- Uses the 256-bit block read/write ports, which the single-cycle word path leaves tied off.
- On a miss it raises STALL_OUT for the hazard unit; the pipeline freezes until the line is resident.

---
 rtl/mips_dcache_wb_pkg.sv | 38 +++
 rtl/mips_dcache_wb_if.sv | 23 ++
 rtl/mips_dcache_wb_merge.sv | 28 ++
 rtl/mips_dcache_wb.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mips_dcache_wb_pkg.sv
// rtl/mips_dcache_wb_pkg.sv - shared types, constants and byte-lane helpers for the write-back data cache
//   state_t        : controller states IDLE / WRITEBACK / REFILL
//   OFFSET_BITS    : byte-offset width within a 32-byte line
//   LINE_BITS      : line width, fixed to the 256-bit block bus
//   size_bytes()   : DataSize encoding (0 means 4) to a byte count
//   byte_mask()    : 32-bit big-endian lane mask for a store of size/offset
package mips_dcache_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_t;

    localparam int OFFSET_BITS = 5;
    localparam int LINE_BITS   = 256;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 3'd4 : {1'b0, size};
    endfunction

    // Lane 0 (offset 0) is bits [31:24]; lanes off..off+n-1 are enabled.
    function automatic logic [31:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        logic [31:0] m;
        logic [2:0]  n;
        logic [2:0]  lo;
        n  = size_bytes(size);
        lo = {1'b0, off};
        m  = '0;
        for (int l = 0; l < 4; l++) begin
            if (3'(l) >= lo && 3'(l) < lo + n) begin
                m[31-8*l -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mips_dcache_wb_if.sv
// rtl/mips_dcache_wb_if.sv - 256-bit block bus between the data cache and data memory
//   master (cache) drives BlockAddress_OUT, MemBlockRead_OUT, MemBlockWrite_OUT, DataBlock_OUT
//   master (cache) samples DataBlock_IN and the one-cycle BlockAck_IN pulse
interface mips_dcache_wb_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] BlockAddress_OUT;
    logic                  MemBlockRead_OUT;
    logic                  MemBlockWrite_OUT;
    logic [255:0]          DataBlock_OUT;
    logic [255:0]          DataBlock_IN;
    logic                  BlockAck_IN;

    modport master (
        output BlockAddress_OUT, MemBlockRead_OUT, MemBlockWrite_OUT, DataBlock_OUT,
        input  DataBlock_IN, BlockAck_IN
    );

    modport slave (
        input  BlockAddress_OUT, MemBlockRead_OUT, MemBlockWrite_OUT, DataBlock_OUT,
        output DataBlock_IN, BlockAck_IN
    );
endinterface

// File: rtl/mips_dcache_wb_merge.sv
// rtl/mips_dcache_wb_merge.sv - combinational big-endian byte-lane merge of store data into a word
//   old_word  in  32  current word from the line
//   wdata     in  32  store data, right-justified
//   size      in  2   bytes to write (0 means 4)
//   off       in  2   byte offset within the word
//   new_word  out 32  merged word
module mips_dcache_merge
    import mips_dcache_wb_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] new_word
);
    logic [31:0] mask;
    logic [2:0]  shamt;
    logic [31:0] aligned;

    // Right-justified data ends at lane off+n-1, so shift left by the lanes
    // remaining after it. Legal (non word-crossing) accesses keep this in 0..3.
    always_comb begin
        mask     = byte_mask(size, off);
        shamt    = 3'd4 - {1'b0, off} - size_bytes(size);
        aligned  = wdata << {shamt, 3'b000};
        new_word = (old_word & ~mask) | (aligned & mask);
    end
endmodule

// File: rtl/mips_dcache_wb.sv
// rtl/mips_dcache_wb.sv - direct-mapped write-back write-allocate data cache for the MEM stage
//   CLOCK, RESET         : clock, synchronous active-high reset
//   Address_IN           : byte address; [4:0] offset, [4:2] word, then index, then tag
//   WriteData_IN         : store data, right-justified
//   DataSize_IN          : bytes to access 1..3, 0 means 4
//   MemRead_IN/Write_IN  : load / store request (both high is a store)
//   ReadData_OUT         : addressed word on a hit, else 0
//   STALL_OUT            : request not complete, pipeline must hold
//   mem                  : block bus (master) for writeback and refill
// Line layout is big-endian throughout: byte offset 0 is bits [255:248],
// word 0 is bits [255:224].
module mips_dcache_wb
    import mips_dcache_wb_pkg::*;
#(
    parameter int NUM_LINES  = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] Address_IN,
    input  logic [31:0]           WriteData_IN,
    input  logic [1:0]            DataSize_IN,
    input  logic                  MemRead_IN,
    input  logic                  MemWrite_IN,
    output logic [31:0]           ReadData_OUT,
    output logic                  STALL_OUT,
    mips_dcache_wb_if.master      mem
);
    localparam int INDEX_BITS = $clog2(NUM_LINES);
    localparam int TAG_BITS   = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]  tag_d  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];
    logic [LINE_BITS-1:0] data_d [NUM_LINES];

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [7:0]            word_lsb;
    logic                  req;
    logic                  hit;
    logic [LINE_BITS-1:0]  cur_line;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;

    logic [ADDR_WIDTH-1:0] block_addr;
    logic                  block_rd;
    logic                  block_wr;
    logic [LINE_BITS-1:0]  block_dout;

    assign req_index = Address_IN[OFFSET_BITS +: INDEX_BITS];
    assign req_tag   = Address_IN[ADDR_WIDTH-1 -: TAG_BITS];
    assign word_lsb  = {3'd7 - Address_IN[4:2], 5'd0};
    assign req       = MemRead_IN | MemWrite_IN;
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign cur_line  = data_q[req_index];
    assign cur_word  = cur_line[word_lsb +: 32];

    mips_dcache_merge u_merge (
        .old_word (cur_word),
        .wdata    (WriteData_IN),
        .size     (DataSize_IN),
        .off      (Address_IN[1:0]),
        .new_word (merged_word)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Line contents need no reset: valid gates every use of them.
    always_ff @(posedge CLOCK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // The index comes from Address_IN in every state because the pipeline
    // holds its inputs stable while STALL_OUT is high.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        STALL_OUT    = 1'b0;
        ReadData_OUT = 32'h0;
        block_addr   = '0;
        block_rd     = 1'b0;
        block_wr     = 1'b0;
        block_dout   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        ReadData_OUT = cur_word;
                        if (MemWrite_IN) begin
                            data_d[req_index][word_lsb +: 32] = merged_word;
                            dirty_d[req_index]                = 1'b1;
                        end
                    end else begin
                        STALL_OUT = 1'b1;
                        state_d   = (valid_q[req_index] && dirty_q[req_index]) ? ST_WRITEBACK : ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                STALL_OUT  = 1'b1;
                block_wr   = 1'b1;
                block_addr = {tag_q[req_index], req_index, {OFFSET_BITS{1'b0}}};
                block_dout = data_q[req_index];
                if (mem.BlockAck_IN) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                STALL_OUT  = 1'b1;
                block_rd   = 1'b1;
                block_addr = {req_tag, req_index, {OFFSET_BITS{1'b0}}};
                if (mem.BlockAck_IN) begin
                    data_d[req_index]  = mem.DataBlock_IN;
                    tag_d[req_index]   = req_tag;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    state_d            = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem.BlockAddress_OUT  = block_addr;
    assign mem.MemBlockRead_OUT  = block_rd;
    assign mem.MemBlockWrite_OUT = block_wr;
    assign mem.DataBlock_OUT     = block_dout;
endmodule
